hazard_ctrl_unit: RTL

Parametrised pipeline hazard controller for the 5-stage pipeline. It replaces the single-cycle load-use detector.
- Detects load-use hazards, with a configurable load-use stall length.
- Tracks a multi-cycle MUL/DIV unit with an internal busy counter and stalls dependent instructions.
- Generates flush controls on taken branches.
- Sits in ID and drives the PC write enable, the IF/ID write enable, the ID/EX bubble mux and the IF/ID flush.

---
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller interface.
// Groups the ID/EX hazard-detection inputs and the pipeline control outputs.
//   master : pipeline side, drives instruction fields and branch result and
//            receives the stall/flush controls.
//   slave  : hazard controller, the reverse of master.
// Handshake: no valid/ready pair here. Every signal is level-sensitive and
// describes the current cycle. The controls take effect at the next rising
// clock edge.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic              ifid_uses_rt;
  logic              ifid_is_md;
  logic              ifid_reads_hilo;
  logic [REG_AW-1:0] idex_rt;
  logic              idex_mem_read;
  logic              ex_branch_taken;
  logic              pc_wr;
  logic              ifid_wr;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              md_busy;
  logic [1:0]        stall_state;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, ifid_is_md, ifid_reads_hilo,
           idex_rt, idex_mem_read, ex_branch_taken,
    input  pc_wr, ifid_wr, idex_bubble, ifid_flush, md_busy, stall_state
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, ifid_is_md, ifid_reads_hilo,
           idex_rt, idex_mem_read, ex_branch_taken,
    output pc_wr, ifid_wr, idex_bubble, ifid_flush, md_busy, stall_state
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage pipeline. It sits in ID.
// It detects load-use hazards and inserts LOAD_STALL bubbles. It tracks the
// multi-cycle MUL/DIV unit and stalls dependent MUL/DIV or MFHI/MFLO
// instructions until the unit is idle. It flushes IF/ID on a taken branch.
// Ports:
//   clk  : pipeline clock
//   rst  : synchronous active-high reset
//   hif  : hazard_ctrl_if.slave. It carries the ID/EX fields in and drives
//          pc_wr, ifid_wr, idex_bubble, ifid_flush, md_busy and
//          stall_state (0 IDLE, 1 LD_STALL, 2 MD_WAIT) out.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MD_LAT     = 8,
  parameter int CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_LAT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic lu, mh, md_busy_int, stall, flush;

  always_comb begin
    md_busy_int = (md_cnt_q != '0);
    lu = hif.idex_mem_read && (hif.idex_rt != '0) &&
         ((hif.idex_rt == hif.ifid_rs) ||
          (hif.ifid_uses_rt && (hif.idex_rt == hif.ifid_rt)));
    mh = md_busy_int && (hif.ifid_is_md || hif.ifid_reads_hilo);

    state_d  = state_q;
    ld_cnt_d = (ld_cnt_q != '0) ? ld_cnt_q - ONE : ld_cnt_q;
    md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - ONE : md_cnt_q;
    stall    = 1'b0;
    flush    = 1'b0;

    if (hif.ex_branch_taken) begin
      // The stalled ID instruction is squashed, so any pending wait is moot.
      // md_cnt keeps counting because the MUL/DIV already issued.
      flush    = 1'b1;
      state_d  = IDLE;
      ld_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lu) begin
            stall = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d  = LD_STALL;
              ld_cnt_d = LD_INIT;
            end
          end else if (mh) begin
            stall = 1'b1;
            // With one busy cycle left, this stall is the last one. Staying
            // in IDLE avoids an extra bubble once md_cnt reaches zero.
            if (md_cnt_q > ONE) state_d = MD_WAIT;
          end
        end
        LD_STALL: begin
          stall = 1'b1;
          if (ld_cnt_q <= ONE) state_d = IDLE;
        end
        MD_WAIT: begin
          stall = 1'b1;
          if (md_cnt_q <= ONE) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (hif.ifid_is_md && !stall && !flush) md_cnt_d = MD_INIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ld_cnt_q <= '0;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    hif.stall_state = state_q;
    hif.md_busy     = !rst && md_busy_int;
    if (rst) begin
      hif.pc_wr       = 1'b0;
      hif.ifid_wr     = 1'b0;
      hif.idex_bubble = 1'b1;
      hif.ifid_flush  = 1'b0;
    end else if (flush) begin
      hif.pc_wr       = 1'b1;
      hif.ifid_wr     = 1'b1;
      hif.idex_bubble = 1'b1;
      hif.ifid_flush  = 1'b1;
    end else if (stall) begin
      hif.pc_wr       = 1'b0;
      hif.ifid_wr     = 1'b0;
      hif.idex_bubble = 1'b1;
      hif.ifid_flush  = 1'b0;
    end else begin
      hif.pc_wr       = 1'b1;
      hif.ifid_wr     = 1'b1;
      hif.idex_bubble = 1'b0;
      hif.ifid_flush  = 1'b0;
    end
  end

endmodule
